// File: rtl/pattern_matcher_multi.sv
// Serial pattern matcher: one shared shift window, several pattern/mask slots,
// saturating bit/match counters with snapshot read and sticky per-slot irq.
module pattern_matcher_multi #(
  parameter int PATTERN_W = 8,
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 32,
  parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 serial_data_in,
  input  logic                 load,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [PATTERN_W-1:0] mask,
  input  logic                 overlap_en,
  input  logic                 read,
  input  logic                 read_and_clear,
  input  logic [IDX_W-1:0]     read_idx,
  input  logic [NUM_SLOTS-1:0] irq_en,
  input  logic [NUM_SLOTS-1:0] irq_clear,
  output logic                 serial_data_out,
  output logic [NUM_SLOTS-1:0] match,
  output logic [CNT_W-1:0]     bit_count,
  output logic [CNT_W-1:0]     match_count,
  output logic [NUM_SLOTS-1:0] irq_pending,
  output logic                 irq
);

  localparam int GAP_W = $clog2(PATTERN_W);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PATTERN_W-1:0] win;
  logic [PATTERN_W-1:0] win_nxt;
  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] sel_load;
  logic [NUM_SLOTS-1:0] sel_read;
  logic [PATTERN_W-1:0] pat [NUM_SLOTS];
  logic [PATTERN_W-1:0] msk [NUM_SLOTS];
  logic [GAP_W-1:0]     gap [NUM_SLOTS];
  logic [CNT_W-1:0]     mcnt [NUM_SLOTS];
  logic [CNT_W-1:0]     bcnt;
  logic [CNT_W-1:0]     mcnt_sel;
  logic                 snap;

  assign win_nxt = {win[PATTERN_W-2:0], serial_data_in};
  assign snap    = read | read_and_clear;

  // Out-of-range indices select no slot, so the snapshot reads as zero.
  always_comb begin
    hit      = '0;
    sel_load = '0;
    sel_read = '0;
    mcnt_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit[i] = valid[i]
            && (((win_nxt ^ pat[i]) & msk[i]) == '0)
            && (overlap_en || gap[i] == GAP_MAX);
      sel_load[i] = load && (load_idx == IDX_W'(i));
      sel_read[i] = (read_idx == IDX_W'(i));
      if (sel_read[i]) mcnt_sel = mcnt[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win             <= '0;
      valid           <= '0;
      bcnt            <= '0;
      serial_data_out <= 1'b0;
      match           <= '0;
      bit_count       <= '0;
      match_count     <= '0;
      irq_pending     <= '0;
      irq             <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pat[i]  <= '0;
        msk[i]  <= '0;
        gap[i]  <= GAP_MAX;
        mcnt[i] <= '0;
      end
    end else begin
      win             <= win_nxt;
      serial_data_out <= serial_data_in;
      match           <= hit;
      irq_pending     <= (irq_pending & ~irq_clear) | hit;
      irq             <= |(irq_pending & irq_en);

      if (snap) begin
        bit_count   <= bcnt;
        match_count <= mcnt_sel;
      end

      // The bit sampled during a clear belongs to the new period.
      if (read_and_clear)
        bcnt <= CNT_W'(1);
      else if (bcnt != CNT_MAX)
        bcnt <= bcnt + 1'b1;

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (sel_load[i]) begin
          valid[i] <= 1'b1;
          pat[i]   <= pattern;
          msk[i]   <= mask;
        end

        if (hit[i])
          gap[i] <= '0;
        else if (sel_load[i])
          gap[i] <= GAP_MAX;
        else if (gap[i] != GAP_MAX)
          gap[i] <= gap[i] + 1'b1;

        if (read_and_clear && sel_read[i])
          mcnt[i] <= {{(CNT_W-1){1'b0}}, hit[i]};
        else if (hit[i] && mcnt[i] != CNT_MAX)
          mcnt[i] <= mcnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_matcher_multi.sv
// Bench for pattern_matcher_multi: directed scenarios plus random traffic
// compared every cycle against a bit-history reference model.
module tb_pattern_matcher_multi;

  localparam int PW   = 8;
  localparam int NS   = 5;
  localparam int CW   = 4;
  localparam int IW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          sdi = 1'b0;
  logic          load = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [PW-1:0] pattern = '0;
  logic [PW-1:0] mask = '0;
  logic          overlap_en = 1'b0;
  logic          read = 1'b0;
  logic          rac = 1'b0;
  logic [IW-1:0] read_idx = '0;
  logic [NS-1:0] irq_en = '0;
  logic [NS-1:0] irq_clear = '0;
  logic          sdo;
  logic [NS-1:0] match;
  logic [CW-1:0] bit_count;
  logic [CW-1:0] match_count;
  logic [NS-1:0] irq_pending;
  logic          irq;

  pattern_matcher_multi #(
    .PATTERN_W(PW), .NUM_SLOTS(NS), .CNT_W(CW), .IDX_W(IW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .serial_data_in(sdi),
    .load(load),
    .load_idx(load_idx),
    .pattern(pattern),
    .mask(mask),
    .overlap_en(overlap_en),
    .read(read),
    .read_and_clear(rac),
    .read_idx(read_idx),
    .irq_en(irq_en),
    .irq_clear(irq_clear),
    .serial_data_out(sdo),
    .match(match),
    .bit_count(bit_count),
    .match_count(match_count),
    .irq_pending(irq_pending),
    .irq(irq)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: bit history, last-hit cycle per slot, plain integers.
  bit            hist[$];
  bit            m_valid[NS];
  logic [PW-1:0] m_pat[NS];
  logic [PW-1:0] m_mask[NS];
  int            m_last[NS];
  int            m_mcnt[NS];
  int            m_bcnt;
  int            cyc;
  logic [NS-1:0] e_match;
  logic [NS-1:0] e_pend;
  logic          e_irq;
  logic          e_sdo;
  logic [CW-1:0] e_bc;
  logic [CW-1:0] e_mc;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0;
      m_pat[i] = '0;
      m_mask[i] = '0;
      m_last[i] = -1000;
      m_mcnt[i] = 0;
    end
    m_bcnt = 0;
    cyc = 0;
    e_match = '0;
    e_pend = '0;
    e_irq = 1'b0;
    e_sdo = 1'b0;
    e_bc = '0;
    e_mc = '0;
  endtask

  task automatic model_step();
    logic [PW-1:0] w;
    logic [NS-1:0] h;
    hist.push_back(sdi);
    if (hist.size() > PW) void'(hist.pop_front());
    w = '0;
    for (int k = 0; k < PW; k++)
      if (hist.size() > k) w[k] = hist[hist.size()-1-k];
    for (int i = 0; i < NS; i++)
      h[i] = m_valid[i] && (((w ^ m_pat[i]) & m_mask[i]) == '0)
             && (overlap_en || (cyc - m_last[i] >= PW));
    if (read || rac) begin
      e_bc = CW'(m_bcnt);
      e_mc = (int'(read_idx) < NS) ? CW'(m_mcnt[read_idx]) : '0;
    end
    m_bcnt = rac ? 1 : ((m_bcnt < MAXC) ? m_bcnt + 1 : MAXC);
    for (int i = 0; i < NS; i++) begin
      if (rac && int'(read_idx) == i) m_mcnt[i] = h[i] ? 1 : 0;
      else if (h[i] && m_mcnt[i] < MAXC) m_mcnt[i]++;
    end
    e_irq = |(e_pend & irq_en);
    e_pend = (e_pend & ~irq_clear) | h;
    e_match = h;
    e_sdo = sdi;
    for (int i = 0; i < NS; i++) begin
      if (h[i]) m_last[i] = cyc;
      else if (load && int'(load_idx) == i) m_last[i] = -1000;
    end
    if (load && int'(load_idx) < NS) begin
      m_valid[load_idx] = 1;
      m_pat[load_idx] = pattern;
      m_mask[load_idx] = mask;
    end
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("match", 32'(match), 32'(e_match));
    chk("sdo", 32'(sdo), 32'(e_sdo));
    chk("bit_count", 32'(bit_count), 32'(e_bc));
    chk("match_count", 32'(match_count), 32'(e_mc));
    chk("irq_pending", 32'(irq_pending), 32'(e_pend));
    chk("irq", 32'(irq), 32'(e_irq));
    load = 1'b0;
    read = 1'b0;
    rac = 1'b0;
    irq_clear = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      sdi = b[k];
      tick();
    end
  endtask

  task automatic do_load(input int idx, input logic [7:0] p,
                         input logic [7:0] m);
    load = 1'b1;
    load_idx = IW'(idx);
    pattern = p;
    mask = m;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_match"}, 32'(match), 0);
    chk({tag, "_sdo"}, 32'(sdo), 0);
    chk({tag, "_bc"}, 32'(bit_count), 0);
    chk({tag, "_mc"}, 32'(match_count), 0);
    chk({tag, "_pend"}, 32'(irq_pending), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_zero("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Exact pattern A5 on slot 0.
    sdi = 0; do_load(0, 8'hA5, 8'hFF); tick();
    send_byte(8'hA5);
    chk("a5_match", 32'(match[0]), 1);
    sdi = 0; read = 1; read_idx = 0; tick();
    chk("a5_count", 32'(match_count), 1);

    // Run of ones, overlapping then non-overlapping.
    overlap_en = 1;
    sdi = 0; do_load(1, 8'hFF, 8'hFF); tick();
    for (int k = 0; k < 16; k++) begin sdi = 1; tick(); end
    sdi = 0; read = 1; read_idx = 1; tick();
    chk("ovl_hits", 32'(match_count), 9);
    for (int k = 0; k < 7; k++) begin sdi = 0; tick(); end
    sdi = 0; rac = 1; read_idx = 1; tick();
    overlap_en = 0;
    for (int k = 0; k < 16; k++) begin sdi = 1; tick(); end
    sdi = 0; read = 1; read_idx = 1; tick();
    chk("novl_hits", 32'(match_count), 2);

    // Upper-nibble mask.
    overlap_en = 1;
    sdi = 0; do_load(2, 8'hF0, 8'hF0); tick();
    send_byte(8'hF3);
    chk("f0_hit", 32'(match[2]), 1);
    send_byte(8'h73);
    chk("f0_nohit", 32'(match[2]), 0);

    // All-don't-care slot 0, counter saturation, out-of-range clear.
    sdi = 0; do_load(0, 8'h00, 8'h00); rac = 1; read_idx = 7; tick();
    chk("oob_mc", 32'(match_count), 0);
    for (int k = 0; k < 20; k++) begin sdi = 1'($urandom); tick(); end
    sdi = 0; read = 1; read_idx = 0; tick();
    chk("sat_mc", 32'(match_count), 15);
    chk("sat_bc", 32'(bit_count), 15);
    sdi = 0; rac = 1; read = 1; read_idx = 0; tick();
    chk("rac_mc", 32'(match_count), 15);
    chk("rac_bc", 32'(bit_count), 15);
    sdi = 0; read = 1; read_idx = 0; tick();
    chk("clr_mc", 32'(match_count), 1);
    chk("clr_bc", 32'(bit_count), 1);

    // Interrupt on slot 3.
    irq_en = 5'b01000;
    sdi = 0; do_load(3, 8'h00, 8'h00); tick();
    sdi = 0; tick();
    chk("pend3", 32'(irq_pending[3]), 1);
    chk("irq_lag", 32'(irq), 0);
    sdi = 0; tick();
    chk("irq_set", 32'(irq), 1);
    sdi = 0; irq_clear = 5'b01000; tick();
    chk("clr_vs_hit", 32'(irq_pending[3]), 1);
    sdi = 0; do_load(3, 8'h55, 8'hFF); tick();
    sdi = 0; irq_clear = 5'b01000; tick();
    chk("pend_clr", 32'(irq_pending[3]), 0);

    // Random traffic with one asynchronous reset mid-stream.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n == 1500) begin
        #2 reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
      end
      sdi = 1'($urandom);
      if ($urandom_range(7) == 0)
        do_load(int'($urandom_range(7)), 8'($urandom),
                8'($urandom & $urandom & $urandom));
      if ($urandom_range(15) == 0) overlap_en = 1'($urandom);
      if ($urandom_range(31) == 0) irq_en = NS'($urandom);
      r = int'($urandom_range(9));
      read = (r == 0) || (r == 2);
      rac = (r == 1) || (r == 2);
      read_idx = IW'($urandom);
      if ($urandom_range(3) == 0) irq_clear = NS'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
